// File: rtl/pe_traceback.sv
// pe_traceback: captures per-anti-diagonal PE pointers, then walks them back from (L-1,L-1) to (0,0) emitting ops.
module pe_traceback #(
  parameter int B = 4,
  parameter int L = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           ptr_valid,
  input  logic [7:0]     ctr,
  input  logic [3*B-1:0] pe_ptr,
  input  logic           op_ready,
  output logic           op_valid,
  output logic [1:0]     op,
  output logic           op_last,
  output logic [7:0]     op_count,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam int N  = 2*L-1;
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(L)+1;
  localparam int LB = $clog2(B);
  typedef enum logic [1:0] {IDLE, CAPTURE, TRACE, DONE} state_t;
  state_t state_q, state_d;
  logic [3*B-1:0] mem_q [N];
  logic [N-1:0] vld_q;
  logic [IW-1:0] i_q, j_q;
  logic [7:0] d_q;
  logic [IW:0] lane;
  logic [2:0] code;
  logic [1:0] sel;
  logic rd, bad, corner, fire, wr, last_wr, dec_i, dec_j;
  assign wr = state_q == CAPTURE && ptr_valid && ctr <= 8'(N-1);
  assign last_wr = wr && ctr == 8'(N-1);
  always_comb begin
    lane = {1'b0, i_q} - {1'b0, j_q} + (IW+1)'(B/2);
    code = mem_q[d_q[AW-1:0]][3*lane[LB-1:0] +: 3];
    corner = i_q == '0 && j_q == '0;
    rd = i_q != '0 && j_q != '0;
    // Any band/address/code violation only matters when the buffer is actually consulted
    bad = rd && (lane >= (IW+1)'(B) || d_q > 8'(N-1) || !vld_q[d_q[AW-1:0]] || code == 3'b000 || code == 3'b111);
    sel = i_q == '0 ? (j_q == '0 ? 2'b01 : 2'b11) : j_q == '0 ? 2'b10 : (code == 3'b100 ? 2'b11 : code[1:0]);
    op_valid = state_q == TRACE && !bad;
    op = op_valid ? sel : 2'b00;
    op_last = op_valid && corner;
    fire = op_valid && op_ready;
    dec_i = sel != 2'b11;
    dec_j = sel != 2'b10;
    busy = state_q == CAPTURE || state_q == TRACE;
    done = state_q == DONE;
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? CAPTURE : IDLE;
      CAPTURE:    state_d = last_wr ? TRACE : CAPTURE;
      TRACE:      state_d = bad ? IDLE : (fire && corner) ? DONE : TRACE;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      err <= 1'b0;
      op_count <= '0;
      vld_q <= '0;
      i_q <= '0;
      j_q <= '0;
      d_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE || state_q == DONE) && start) begin
        err <= 1'b0;
        op_count <= '0;
        vld_q <= '0;
      end
      if (wr) vld_q[ctr[AW-1:0]] <= 1'b1;
      if (last_wr) begin
        i_q <= IW'(L-1);
        j_q <= IW'(L-1);
        d_q <= 8'(N-1);
      end
      if (state_q == TRACE && bad) err <= 1'b1;
      if (fire) begin
        op_count <= op_count + 8'd1;
        i_q <= i_q - IW'(dec_i);
        j_q <= j_q - IW'(dec_j);
        d_q <= d_q - 8'(dec_i) - 8'(dec_j);
      end
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[ctr[AW-1:0]] <= pe_ptr;
endmodule

// File: tb/tb_pe_traceback.sv
// tb_pe_traceback: randomized and directed checks of pe_traceback against a path-walking reference model.
module tb_pe_traceback;
  logic clk = 0, reset = 0, start = 0, ptr_valid = 0, op_ready = 0;
  logic [7:0] ctr = 0;
  logic [11:0] pe_ptr = 0;
  logic op_valid, op_last, busy, done, err;
  logic [1:0] op;
  logic [7:0] op_count;
  int checks = 0, errors = 0;
  logic [11:0] mem [15];
  int exp_op [$];
  bit exp_err;

  pe_traceback #(.B(4), .L(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ptr_valid(ptr_valid), .ctr(ctr),
    .pe_ptr(pe_ptr), .op_ready(op_ready), .op_valid(op_valid), .op(op),
    .op_last(op_last), .op_count(op_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic void fill(input logic [2:0] c);
    for (int d = 0; d < 15; d++) mem[d] = {4{c}};
  endfunction

  function automatic void set_lane(input int d, input int k, input logic [2:0] c);
    mem[d][3*k +: 3] = c;
  endfunction

  function automatic void rand_mem();
    for (int d = 0; d < 15; d++)
      for (int k = 0; k < 4; k++) begin
        int r = $urandom_range(99);
        bit a = 1'($urandom_range(1));
        set_lane(d, k, r < 70 ? (a ? 3'b101 : 3'b001) : r < 82 ? (a ? 3'b110 : 3'b010) :
                       r < 95 ? (a ? 3'b100 : 3'b011) : (a ? 3'b111 : 3'b000));
      end
  endfunction

  // Walk the alignment path from the far corner using the cell/lane rules directly
  function automatic void model();
    int i = 7, j = 7, k, c;
    exp_op.delete();
    exp_err = 0;
    while (1) begin
      if (i == 0 && j == 0) begin exp_op.push_back(1); break; end
      if (i == 0) begin exp_op.push_back(3); j--; end
      else if (j == 0) begin exp_op.push_back(2); i--; end
      else begin
        k = i - j + 2;
        if (k < 0 || k > 3) begin exp_err = 1; break; end
        c = int'((mem[i+j] >> (3*k)) & 12'h7);
        if (c == 0 || c == 7) begin exp_err = 1; break; end
        if (c == 1 || c == 5) begin exp_op.push_back(1); i--; j--; end
        else if (c == 2 || c == 6) begin exp_op.push_back(2); i--; end
        else begin exp_op.push_back(3); j--; end
      end
    end
  endfunction

  task automatic feed();
    for (int d = 0; d < 15; d++) begin
      while ($urandom_range(3) == 0) begin
        ptr_valid = 1'($urandom_range(1));
        ctr = 8'($urandom_range(255, 15));
        pe_ptr = 12'($urandom);
        @(negedge clk);
      end
      ptr_valid = 1; ctr = 8'(d); pe_ptr = mem[d];
      @(negedge clk);
    end
    ptr_valid = 0; ctr = 0; pe_ptr = 0;
  endtask

  task automatic run(input int rmode, input bit pre, input int abort_at, input bit poke_start, input bit chain);
    int idx = 0;
    bit stalled = 0, seen_done = 0, rdy;
    logic [2:0] held = 0;
    model();
    if (!pre) begin start = 1; @(negedge clk); start = 0; end
    chk("busy_cap", busy, 1);
    chk("err_clr", err, 0);
    chk("cnt_clr", op_count, 0);
    feed();
    for (int c = 0; c < 300; c++) begin
      if (done) begin seen_done = 1; break; end
      if (err) break;
      if (stalled) chk("vld_hold", op_valid, 1);
      if (op_valid && idx == abort_at) begin
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("rst_out", {op_valid, op, op_last, op_count, busy, done, err}, 0);
        for (int w = 0; w < 4; w++) begin @(negedge clk); chk("rst_nodone", done, 0); end
        return;
      end
      rdy = rmode == 0 ? 1'b1 : rmode == 1 ? bit'(c % 3 == 0) : 1'($urandom_range(1));
      start = poke_start ? 1'($urandom_range(1)) : 1'b0;
      if (op_valid) begin
        if (stalled) chk("op_hold", {op, op_last}, held);
        if (rdy) begin
          chk("op", op, idx < exp_op.size() ? exp_op[idx] : 0);
          chk("last", op_last, !exp_err && idx == exp_op.size() - 1);
          idx++;
        end
        stalled = !rdy;
        held = {op, op_last};
      end else stalled = 0;
      op_ready = rdy;
      @(negedge clk);
      chk("cnt", op_count, idx);
    end
    start = 0; op_ready = 0;
    chk("nops", idx, exp_op.size());
    chk("err", err, exp_err);
    chk("done", seen_done, !exp_err);
    chk("op_count", op_count, exp_op.size());
    chk("busy_end", busy, 0);
    chk("vld_end", op_valid, 0);
    if (chain) begin start = 1; @(negedge clk); start = 0; end
    else begin @(negedge clk); chk("done_pulse", done, 0); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", {op_valid, op, op_last, op_count, busy, done, err}, 0);
    reset = 1;
    @(negedge clk);
    fill(3'b001); run(0, 0, -1, 0, 0);
    fill(3'b001); set_lane(14, 2, 3'b010); set_lane(13, 1, 3'b011); run(0, 0, -1, 0, 0);
    fill(3'b001); run(1, 0, -1, 0, 0);
    fill(3'b001); set_lane(12, 2, 3'b111); run(0, 0, -1, 0, 0);
    fill(3'b001); set_lane(14, 2, 3'b010); set_lane(13, 1, 3'b010); set_lane(12, 0, 3'b010); run(0, 0, -1, 0, 0);
    fill(3'b001); run(0, 0, 3, 0, 0);
    fill(3'b001); run(2, 0, -1, 1, 1);
    rand_mem(); run(2, 1, -1, 0, 0);
    for (int t = 0; t < 30; t++) begin
      rand_mem();
      run(int'($urandom_range(2)), 0, -1, 1'($urandom_range(1)), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
